// File: rtl/ring_modulator_if.sv
// ring_modulator_if: sample-side bus of ring_modulator; am_mode exists only with RINGMOD_AM_EN.
interface ring_modulator_if #(
    parameter int BITSIZE   = 16,
    parameter int CHANNELS  = 2,
    parameter int DEPTHBITS = 8
);
    logic                         lrclk;
    logic [CHANNELS*BITSIZE-1:0]  in_a;
    logic [CHANNELS*BITSIZE-1:0]  in_b;
    logic [DEPTHBITS:0]           depth;
`ifdef RINGMOD_AM_EN
    logic                         am_mode;
`endif
    logic [CHANNELS*BITSIZE-1:0]  out;
    logic                         valid;
    logic                         busy;
    logic                         overrun;
    modport master (
`ifdef RINGMOD_AM_EN
        output am_mode,
`endif
        output lrclk, in_a, in_b, depth,
        input  out, valid, busy, overrun
    );
    modport slave (
`ifdef RINGMOD_AM_EN
        input  am_mode,
`endif
        input  lrclk, in_a, in_b, depth,
        output out, valid, busy, overrun
    );
endinterface

// File: rtl/ring_modulator.sv
// ring_modulator: time-shared serial shift-add ring modulator with dry/wet mix per channel.
// Define RINGMOD_AM_EN to add am_mode (unipolar AM operand substitution).
module ring_modulator #(
    parameter int BITSIZE   = 16,
    parameter int CHANNELS  = 2,
    parameter int DEPTHBITS = 8
) (
    input logic              clk,
    input logic              reset,
    ring_modulator_if.slave  bus
);
    localparam int B  = BITSIZE;
    localparam int C  = CHANNELS;
    localparam int D  = DEPTHBITS;
    localparam int W  = B + D + 2;
    localparam int CW = C > 1 ? $clog2(C) : 1;
    localparam int NW = $clog2(B);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, MIX, DONE} state_t;
    state_t state_q, state_d;
    logic lr_q, lr_d, ovr_q, ovr_d;
    logic [C*B-1:0] out_q, out_d;
    logic signed [B-1:0] a_q [C], a_d [C], b_q [C], b_d [C], st_q [C], st_d [C];
    logic [D:0] dep_q, dep_d;
    logic [2*B-1:0] prod_q, prod_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ch_q, ch_d;
    logic rise, last_bit, last_ch, neg;
    logic signed [B-1:0] a_ch, b_ch, a_mul, wet;
    logic [B-1:0] ma, mb;
    logic [B:0] sum;
    logic signed [2*B:0] p;
    logic signed [W-1:0] wet_x, a_x, dep_x, inv_x, mix_full;
`ifdef RINGMOD_AM_EN
    logic am_q, am_d;
    logic signed [B-1:0] a_half;
    assign am_d = state_q == LOAD ? bus.am_mode : am_q;
    always_ff @(posedge clk) am_q <= am_d;
`endif
    assign rise     = bus.lrclk & ~lr_q;
    assign last_bit = cnt_q == NW'(B - 1);
    assign last_ch  = ch_q == CW'(C - 1);
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (rise ? LOAD : IDLE)
                : state_q == LOAD ? MUL
                : state_q == MUL  ? (last_bit ? MIX : MUL)
                : state_q == MIX  ? (last_ch ? DONE : MUL)
                : IDLE;
    end
    always_comb begin
        bus.busy    = state_q != IDLE;
        bus.valid   = state_q == DONE;
        bus.out     = out_q;
        bus.overrun = ovr_q;
    end
    always_comb begin
        a_ch = a_q[ch_q];
        b_ch = b_q[ch_q];
`ifdef RINGMOD_AM_EN
        a_half = a_ch >>> 1;
        a_mul  = am_q ? a_half + {2'b01, {(B-2){1'b0}}} : a_ch;
`else
        a_mul = a_ch;
`endif
        ma  = a_mul[B-1] ? -a_mul : a_mul;
        mb  = b_ch[B-1] ? -b_ch : b_ch;
        neg = a_mul[B-1] ^ b_ch[B-1];
        sum = {1'b0, prod_q[2*B-1:B]} + {1'b0, (mb[cnt_q] ? ma : B'(0))};
        p   = neg ? -$signed({1'b0, prod_q}) : $signed({1'b0, prod_q});
        // Only (-2^(B-1))^2 reaches bit 2B-2, and that case must saturate
        wet = prod_q[2*B-2] ? {1'b0, {(B-1){1'b1}}} : p[2*B-2:B-1];
        wet_x    = W'(wet);
        a_x      = W'(a_ch);
        dep_x    = W'(dep_q);
        inv_x    = W'({1'b1, {D{1'b0}}} - dep_q);
        mix_full = wet_x * dep_x + a_x * inv_x;
    end
    always_comb begin
        lr_d   = bus.lrclk;
        ovr_d  = ovr_q | (rise & (state_q != IDLE));
        a_d    = a_q;
        b_d    = b_q;
        dep_d  = dep_q;
        st_d   = st_q;
        out_d  = out_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        ch_d   = state_q == DONE ? '0 : ch_q;
        if (state_q == LOAD) begin
            for (int i = 0; i < C; i++) begin
                a_d[i] = bus.in_a[i*B +: B];
                b_d[i] = bus.in_b[i*B +: B];
            end
            dep_d  = bus.depth[D] ? {1'b1, {D{1'b0}}} : bus.depth;
            prod_d = '0;
            cnt_d  = '0;
            ch_d   = '0;
        end
        if (state_q == MUL) begin
            prod_d = {sum, prod_q[B-1:1]};
            cnt_d  = cnt_q + 1'b1;
        end
        if (state_q == MIX) begin
            st_d[ch_q] = mix_full[B+D-1:D];
            prod_d     = '0;
            cnt_d      = '0;
            ch_d       = last_ch ? ch_q : ch_q + 1'b1;
            if (last_ch)
                for (int i = 0; i < C; i++) out_d[i*B +: B] = st_d[i];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_q  <= 1'b0;
            ovr_q <= 1'b0;
            out_q <= '0;
            ch_q  <= '0;
        end else begin
            lr_q  <= lr_d;
            ovr_q <= ovr_d;
            out_q <= out_d;
            ch_q  <= ch_d;
        end
        a_q    <= a_d;
        b_q    <= b_d;
        st_q   <= st_d;
        dep_q  <= dep_d;
        prod_q <= prod_d;
        cnt_q  <= cnt_d;
    end
endmodule

// File: tb/tb_ring_modulator.sv
// tb_ring_modulator: table vectors, randomized runs against an arithmetic model, and
// hand sequences for latency, overrun and mid-run reset.
module tb_ring_modulator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    ring_modulator_if #(.BITSIZE(16), .CHANNELS(2), .DEPTHBITS(8)) bus ();
    ring_modulator #(.BITSIZE(16), .CHANNELS(2), .DEPTHBITS(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    typedef struct {
        logic [15:0] a0, b0, a1, b1;
        logic [8:0]  dep;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t vt [9];
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic logic [15:0] model(input logic signed [15:0] a, input logic signed [15:0] b,
                                          input int dep, input bit am);
        longint am_a, prod, wet, d, mix;
        am_a = am ? (longint'(a) >>> 1) + 16384 : longint'(a);
        prod = am_a * longint'(b);
        wet  = prod >>> 15;
        if (wet > 32767) wet = 32767;
        d    = dep > 256 ? 256 : dep;
        mix  = (wet * d + longint'(a) * (256 - d)) >>> 8;
        return mix[15:0];
    endfunction
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [8:0] dep,
                       input bit am, output logic [31:0] got, output int lat);
        @(negedge clk);
        bus.in_a = a;
        bus.in_b = b;
        bus.depth = dep;
`ifdef RINGMOD_AM_EN
        bus.am_mode = am;
`endif
        bus.lrclk = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) begin
                bus.lrclk = 1'b0;
                bus.in_a = $urandom;
                bus.in_b = $urandom;
                bus.depth = 9'($urandom);
`ifdef RINGMOD_AM_EN
                bus.am_mode = ~am;
`endif
            end
        end while (!bus.valid && lat < 200);
        got = bus.out;
        @(posedge clk);
        #1;
        check("valid_pulse", {31'b0, bus.valid}, 32'd0);
    endtask
    initial begin
        logic [31:0] got, a, b;
        logic [8:0] dep;
        int lat, nv;
        bit am;
        vt[0] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 9'd256, 16'h2000, 16'h2000};
        vt[1] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 9'd256, 16'h7FFF, 16'h8001};
        vt[2] = '{16'h1234, 16'h5678, 16'h8000, 16'h7FFF, 9'd0,   16'h1234, 16'h8000};
        vt[3] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 9'd128, 16'h3000, 16'h3000};
        vt[4] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000, 9'h1FF, 16'h2000, 16'h7FFF};
        vt[5] = '{16'h4000, 16'hC000, 16'h2000, 16'h4000, 9'd256, 16'hE000, 16'h1000};
        vt[6] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 9'd256, 16'hFFFF, 16'h0000};
        vt[7] = '{16'h4000, 16'h4000, 16'h7FFF, 16'h7FFF, 9'd257, 16'h2000, 16'h7FFE};
        vt[8] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 9'd128, 16'hFFFF, 16'h0000};
        bus.lrclk = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.depth = '0;
`ifdef RINGMOD_AM_EN
        bus.am_mode = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_out", bus.out, 32'd0);
        check("reset_valid", {31'b0, bus.valid}, 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_overrun", {31'b0, bus.overrun}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            run({vt[i].a1, vt[i].a0}, {vt[i].b1, vt[i].b0}, vt[i].dep, 1'b0, got, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd36);
            check($sformatf("vec%0d_ch0", i), {16'b0, got[15:0]}, {16'b0, vt[i].e0});
            check($sformatf("vec%0d_ch1", i), {16'b0, got[31:16]}, {16'b0, vt[i].e1});
        end
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            dep = 9'($urandom_range(0, 511));
`ifdef RINGMOD_AM_EN
            am = 1'($urandom);
`else
            am = 1'b0;
`endif
            run(a, b, dep, am, got, lat);
            check($sformatf("rand%0d_ch0", i), {16'b0, got[15:0]}, {16'b0, model(a[15:0], b[15:0], int'(dep), am)});
            check($sformatf("rand%0d_ch1", i), {16'b0, got[31:16]}, {16'b0, model(a[31:16], b[31:16], int'(dep), am)});
        end
        check("no_spurious_overrun", {31'b0, bus.overrun}, 32'd0);
        @(negedge clk);
        bus.in_a = 32'h4000_4000;
        bus.in_b = 32'h4000_4000;
        bus.depth = 9'd256;
`ifdef RINGMOD_AM_EN
        bus.am_mode = 1'b0;
`endif
        bus.lrclk = 1'b1;
        nv = 0;
        got = '0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) bus.lrclk = 1'b0;
            if (c == 10) bus.lrclk = 1'b1;
            if (bus.valid) begin
                nv++;
                got = bus.out;
            end
        end
        bus.lrclk = 1'b0;
        check("overrun_valid_count", nv, 32'd1);
        check("overrun_result", got, 32'h2000_2000);
        check("overrun_sticky", {31'b0, bus.overrun}, 32'd1);
        @(negedge clk);
        bus.in_a = 32'h1234_5678;
        bus.in_b = 32'h7000_3000;
        bus.lrclk = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.lrclk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", bus.out, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_overrun", {31'b0, bus.overrun}, 32'd0);
        nv = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid) nv++;
        end
        check("abort_no_valid", nv, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
